// File: rtl/reaction_timer_core_if.sv
// rtl/reaction_timer_core_if.sv - player inputs and display/status outputs of the reaction timer
// Signals:
//   start, press        game enable level and synchronised button (into the core)
//   seg, digit_sel      multiplexed seven-segment drive, one-hot digit select
//   go_led, state       PLAY indicator and FSM state (IDLE=0 WAIT=1 PLAY=2 DONE=3)
//   time_bcd            elapsed count, packed BCD, digit 0 least significant
//   early, done         early-press flag and one-cycle DONE entry pulse
//   best_bcd, new_best  best-time register and its update pulse (REACTION_BEST_EN only)
// Modports: slave = core side, master = driver/observer side.
interface reaction_timer_core_if #(
   parameter int NUM_DIGITS = 2
);
   logic                    start;
   logic                    press;
   logic [6:0]              seg;
   logic [NUM_DIGITS-1:0]   digit_sel;
   logic                    go_led;
   logic [1:0]              state;
   logic [4*NUM_DIGITS-1:0] time_bcd;
   logic                    early;
   logic                    done;
`ifdef REACTION_BEST_EN
   logic [4*NUM_DIGITS-1:0] best_bcd;
   logic                    new_best;
`endif

   modport slave (
      input  start, input press,
      output seg, output digit_sel, output go_led, output state,
      output time_bcd, output early, output done
`ifdef REACTION_BEST_EN
      , output best_bcd, output new_best
`endif
   );

   modport master (
      output start, output press,
      input  seg, input digit_sel, input go_led, input state,
      input  time_bcd, input early, input done
`ifdef REACTION_BEST_EN
      , input best_bcd, input new_best
`endif
   );
endinterface

// File: rtl/reaction_timer_core.sv
// rtl/reaction_timer_core.sv - reaction-time game core with random wait and seven-segment scan
// Optional feature macro: REACTION_BEST_EN (best-time register, best_bcd/new_best on the interface).
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    reaction_timer_core_if.slave: start/press in; seg, digit_sel, go_led, state,
//          time_bcd, early, done (and best_bcd, new_best) out
module reaction_timer_core #(
   parameter int TICK_DIV     = 2_000_000,
   parameter int NUM_DIGITS   = 2,
   parameter int DISP_DIV     = 4,
   parameter int DELAY_MIN    = 10,
   parameter int DELAY_RAND_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   reaction_timer_core_if.slave  bus
);
   localparam int TW = $clog2(TICK_DIV);
   localparam int SW = $clog2(DISP_DIV + 1);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int DW = $clog2(DELAY_MIN + (1 << DELAY_RAND_W) + 1);
   localparam int BW = 4 * NUM_DIGITS;
   localparam logic [BW-1:0]         ALL_NINES = {NUM_DIGITS{4'h9}};
   localparam logic [NUM_DIGITS-1:0] SEL0      = 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_PLAY = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                st;
   logic [TW-1:0]         tick_ctr;
   logic                  tick;
   logic [15:0]           lfsr;
   logic                  press_q;
   logic                  press_edge;
   logic [DW-1:0]         delay;
   logic [BW-1:0]         time_q;
   logic                  early_q;
   logic                  done_q;
   logic                  go_q;
   logic [SW-1:0]         scan_ctr;
   logic [IW-1:0]         idx;
   logic [IW-1:0]         idx_nxt;
   logic [6:0]            seg_q;
   logic [NUM_DIGITS-1:0] sel_q;
`ifdef REACTION_BEST_EN
   logic [BW-1:0]         best_q;
   logic                  new_best_q;
`endif

   function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
      logic [BW-1:0] r;
      logic          c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (c) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   assign tick       = (tick_ctr == TW'(TICK_DIV - 1));
   assign press_edge = bus.press & ~press_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         tick_ctr <= '0;
         lfsr     <= 16'hACE1;
      end else begin
         tick_ctr <= tick ? '0 : tick_ctr + 1'b1;
         // Taps 16,14,13,11 in right-shift form; the seed keeps it off the all-zero lockup state.
         lfsr     <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st         <= S_IDLE;
         press_q    <= 1'b0;
         delay      <= '0;
         time_q     <= '0;
         early_q    <= 1'b0;
         done_q     <= 1'b0;
         go_q       <= 1'b0;
`ifdef REACTION_BEST_EN
         best_q     <= ALL_NINES;
         new_best_q <= 1'b0;
`endif
      end else begin
         press_q <= bus.press;
         done_q  <= 1'b0;
`ifdef REACTION_BEST_EN
         new_best_q <= 1'b0;
`endif
         case (st)
            S_IDLE: begin
               // Raw level check: a button held from the last game cannot arm a new one.
               if (bus.start && !bus.press) begin
                  st      <= S_WAIT;
                  delay   <= DW'(DELAY_MIN) + DW'(lfsr[DELAY_RAND_W-1:0]);
                  time_q  <= '0;
                  early_q <= 1'b0;
               end
            end
            S_WAIT: begin
               if (!bus.start) begin
                  st     <= S_IDLE;
                  time_q <= '0;
               end else if (press_edge) begin
                  st      <= S_DONE;
                  early_q <= 1'b1;
                  done_q  <= 1'b1;
               end else if (tick) begin
                  if (delay == DW'(1)) begin
                     st   <= S_PLAY;
                     go_q <= 1'b1;
                  end else begin
                     delay <= delay - 1'b1;
                  end
               end
            end
            S_PLAY: begin
               if (!bus.start) begin
                  st     <= S_IDLE;
                  go_q   <= 1'b0;
                  time_q <= '0;
               end else if (press_edge) begin
                  // A tick in the same cycle is dropped: the player stopped the clock first.
                  st     <= S_DONE;
                  go_q   <= 1'b0;
                  done_q <= 1'b1;
`ifdef REACTION_BEST_EN
                  if (time_q < best_q) begin
                     best_q     <= time_q;
                     new_best_q <= 1'b1;
                  end
`endif
               end else if (tick) begin
                  if (time_q == ALL_NINES) begin
                     st     <= S_DONE;
                     go_q   <= 1'b0;
                     done_q <= 1'b1;
                  end else begin
                     time_q <= bcd_inc(time_q);
                  end
               end
            end
            S_DONE: begin
               if (!bus.start) begin
                  st <= S_IDLE;
               end
            end
            default: st <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      idx_nxt = idx;
      if (scan_ctr == SW'(DISP_DIV - 1)) begin
         idx_nxt = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end
   end

   // Segment data and digit select come from the same index on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         scan_ctr <= '0;
         idx      <= '0;
         seg_q    <= 7'h00;
         sel_q    <= SEL0;
      end else begin
         scan_ctr <= (scan_ctr == SW'(DISP_DIV - 1)) ? '0 : scan_ctr + 1'b1;
         idx      <= idx_nxt;
         sel_q    <= SEL0 << idx_nxt;
         if (st == S_IDLE || st == S_WAIT) begin
            seg_q <= 7'h00;
         end else if (early_q) begin
            seg_q <= 7'b1000000;
         end else begin
            seg_q <= seg_decode(time_q[{idx_nxt, 2'b00} +: 4]);
         end
      end
   end

   assign bus.seg       = seg_q;
   assign bus.digit_sel = sel_q;
   assign bus.go_led    = go_q;
   assign bus.state     = st;
   assign bus.time_bcd  = time_q;
   assign bus.early     = early_q;
   assign bus.done      = done_q;
`ifdef REACTION_BEST_EN
   assign bus.best_bcd  = best_q;
   assign bus.new_best  = new_best_q;
`endif
endmodule
